haar_database_streamer: RTL and testbench
=========================================

// Module: haar_database_streamer
// PURPOSE
//  Responder side of the classifier-database handshake: the consumer raises database_request;
//  this block streams one stage's Haar parameters from a synchronous ROM, one word per cycle.
//  Each word carries tree/classifier/param indices and end-of-classifier/tree/stage markers.
//  The top level instantiates one streamer per stage and drives the per-stage lanes of the consumer.
// PARAMETERS
//  DATA_WIDTH_12            12   width of data word and of every index output
//  NUM_TREES                2    trees in this stage
//  NUM_CLASSIFIER_PER_TREE  3    classifiers per tree
//  NUM_PARAM_PER_CLASSIFIER 18   parameter words per classifier
//  ROM_ADDR_WIDTH           12   ROM address width
//  BASE_ADDR                0    ROM address of the stage's first word
// PORTS
//  clk_fpga               in   1    single clock; all logic on rising edge
//  reset_fpga             in   1    synchronous, active-low reset
//  database_request       in   1    level request from the consumer; low = abort/idle
//  rom_rdata              in   12   ROM read data; valid one cycle after o_rom_addr is sampled
//  o_rom_addr             out  ROM_ADDR_WIDTH  ROM read address (registered)
//  o_valid                out  1    data/index outputs valid this cycle
//  o_data                 out  12   parameter word (= rom_rdata, gated to 0 when !o_valid)
//  o_index_database       out  12   param index within classifier, 0..P-1
//  o_index_classifier     out  12   classifier index within tree, 0..C-1
//  o_index_tree           out  12   tree index within stage, 0..T-1
//  o_end_single_classifier out 1    valid word is the last param of a classifier
//  o_end_tree             out  1    valid word is the last param of a tree
//  o_end_all_classifier   out  1    valid word is the last word of the stage
//  o_end_database         out  1    stage fully delivered; level until request drops
// BEHAVIOUR
//  - N = T*C*P words per stage. Counters p,c,t registered, DATA_WIDTH_12 wide, zero-extended.
//  - States: IDLE, STREAM, DONE. Reset (reset_fpga==0 at an edge): state IDLE, p=c=t=0,
//    o_rom_addr=BASE_ADDR, o_valid=0, o_data=0, all end flags 0, o_end_database=0.
//  - IDLE: o_rom_addr=BASE_ADDR. request==1 at edge -> STREAM, addr<=BASE_ADDR+1.
//    ROM sampled BASE_ADDR on that edge, so word 0 appears the next cycle: latency 1 cycle.
//  - STREAM: o_valid = request (combinational; dropping request kills o_valid same cycle).
//    Each edge with request==1: addr++, p++; p==P-1 -> p=0,c++; c wraps at C-1 -> t++.
//    Flags are combinational from counters while o_valid: end_single = (p==P-1);
//    end_tree = end_single && c==C-1; end_all = end_tree && t==T-1.
//    Edge with end_all word -> DONE, counters 0, addr<=BASE_ADDR.
//  - DONE: o_valid=0, o_end_database=1 (registered). request==0 at edge -> IDLE.
//    A new stream requires request low for >=1 edge (no back-to-back restart from DONE).
//  - Abort: request==0 at an edge in STREAM -> IDLE, counters 0, addr<=BASE_ADDR, no end
//    flags emitted; the next request restarts from word 0 (no resume).
//  - Reset asserted mid-stream wins over all transitions; same result as reset from idle.
//  - P==1 or C==1 or T==1 must work: flags then coincide on the same word.
//  - Address never exceeds BASE_ADDR+N; no wrap of the ROM address beyond the stage.
// TESTING
//  T1 reset: hold reset_fpga=0 3 cycles mid-stream -> o_valid=0, o_rom_addr=0, all flags 0.
//  T2 full stage T=2,C=3,P=18, ROM[a]=a: raise request -> first o_valid 1 cycle later with
//     o_data=0, 108 consecutive valid words o_data=0..107, end_single on words 17,35,..,107,
//     end_tree on 53,107, end_all only on 107; then o_end_database=1, o_valid=0.
//  T3 abort: drop request after word 40 -> o_valid=0 that cycle, next request restarts at
//     o_data=0, idx (0,0,0); no end_all seen before word 107.
//  T4 DONE hold: keep request high 10 cycles after word 107 -> o_end_database stays 1, no
//     new words; drop then raise -> fresh stream from word 0, o_end_database cleared.
//  T5 degenerate T=1,C=1,P=1: one request -> single word with all three end flags set.
//  T6 BASE_ADDR=200: first o_rom_addr in IDLE = 200; last sampled address = 307.

Source files
------------

// File: rtl/haar_database_streamer.sv
// Streams one stage of Haar classifier parameters from a synchronous ROM.
// Each word is tagged with tree/classifier/param indices and end markers.
module haar_database_streamer #(
  parameter int DATA_WIDTH_12            = 12,
  parameter int NUM_TREES                = 2,
  parameter int NUM_CLASSIFIER_PER_TREE  = 3,
  parameter int NUM_PARAM_PER_CLASSIFIER = 18,
  parameter int ROM_ADDR_WIDTH           = 12,
  parameter int BASE_ADDR                = 0
) (
  input  logic                      clk_fpga,
  input  logic                      reset_fpga,
  input  logic                      database_request,
  input  logic [DATA_WIDTH_12-1:0]  rom_rdata,
  output logic [ROM_ADDR_WIDTH-1:0] o_rom_addr,
  output logic                      o_valid,
  output logic [DATA_WIDTH_12-1:0]  o_data,
  output logic [DATA_WIDTH_12-1:0]  o_index_database,
  output logic [DATA_WIDTH_12-1:0]  o_index_classifier,
  output logic [DATA_WIDTH_12-1:0]  o_index_tree,
  output logic                      o_end_single_classifier,
  output logic                      o_end_tree,
  output logic                      o_end_all_classifier,
  output logic                      o_end_database
);

  localparam int DW = DATA_WIDTH_12;
  localparam int AW = ROM_ADDR_WIDTH;

  localparam logic [DW-1:0] P_LAST = DW'(NUM_PARAM_PER_CLASSIFIER - 1);
  localparam logic [DW-1:0] C_LAST = DW'(NUM_CLASSIFIER_PER_TREE - 1);
  localparam logic [DW-1:0] T_LAST = DW'(NUM_TREES - 1);
  localparam logic [AW-1:0] BASE   = AW'(BASE_ADDR);
  localparam logic [DW-1:0] ONE    = DW'(1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   p_q, p_d;
  logic [DW-1:0]   c_q, c_d;
  logic [DW-1:0]   t_q, t_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            valid;
  logic            end_single;
  logic            end_tree;
  logic            end_all;

  always_ff @(posedge clk_fpga) begin
    if (!reset_fpga) begin
      state_q <= IDLE;
      p_q     <= '0;
      c_q     <= '0;
      t_q     <= '0;
      addr_q  <= BASE;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      c_q     <= c_d;
      t_q     <= t_d;
      addr_q  <= addr_d;
    end
  end

  // Dropping the request kills the current word in the same cycle.
  assign valid      = (state_q == STREAM) && database_request;
  assign end_single = valid && (p_q == P_LAST);
  assign end_tree   = end_single && (c_q == C_LAST);
  assign end_all    = end_tree && (t_q == T_LAST);

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    c_d     = c_q;
    t_d     = t_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        addr_d = BASE;
        if (database_request) begin
          state_d = STREAM;
          addr_d  = BASE + AW'(1);
        end
      end
      STREAM: begin
        if (!database_request || end_all) begin
          state_d = database_request ? DONE : IDLE;
          p_d     = '0;
          c_d     = '0;
          t_d     = '0;
          addr_d  = BASE;
        end else begin
          addr_d = addr_q + AW'(1);
          if (p_q == P_LAST) begin
            p_d = '0;
            if (c_q == C_LAST) begin
              c_d = '0;
              t_d = t_q + ONE;
            end else begin
              c_d = c_q + ONE;
            end
          end else begin
            p_d = p_q + ONE;
          end
        end
      end
      DONE: begin
        if (!database_request) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_rom_addr              = addr_q;
  assign o_valid                 = valid;
  assign o_data                  = valid ? rom_rdata : '0;
  assign o_index_database        = p_q;
  assign o_index_classifier      = c_q;
  assign o_index_tree            = t_q;
  assign o_end_single_classifier = end_single;
  assign o_end_tree              = end_tree;
  assign o_end_all_classifier    = end_all;
  assign o_end_database          = (state_q == DONE);

endmodule

// File: tb/tb_haar_database_streamer.sv
// Directed bench: full stage, abort, DONE hold, degenerate shape, offset base.
module tb_haar_database_streamer;

  logic clk_fpga = 1'b0;
  logic reset_fpga = 1'b0;
  always #5 clk_fpga = ~clk_fpga;

  int checks = 0;
  int passes = 0;

  // main instance: T=2 C=3 P=18 base 0
  logic        req_a = 1'b0;
  logic [11:0] rom_a, addr_a, data_a, ip_a, ic_a, it_a;
  logic        v_a, es_a, et_a, ea_a, ed_a;
  // degenerate instance: T=C=P=1
  logic        req_b = 1'b0;
  logic [11:0] rom_b, addr_b, data_b, ip_b, ic_b, it_b;
  logic        v_b, es_b, et_b, ea_b, ed_b;
  // offset instance: base 200
  logic        req_c = 1'b0;
  logic [11:0] rom_c, addr_c, data_c, ip_c, ic_c, it_c;
  logic        v_c, es_c, et_c, ea_c, ed_c;

  // Synchronous ROM with ROM[a] = a
  always @(posedge clk_fpga) begin
    rom_a <= addr_a;
    rom_b <= addr_b;
    rom_c <= addr_c;
  end

  haar_database_streamer #(
    .NUM_TREES(2), .NUM_CLASSIFIER_PER_TREE(3),
    .NUM_PARAM_PER_CLASSIFIER(18), .BASE_ADDR(0)
  ) dut_a (
    .clk_fpga(clk_fpga), .reset_fpga(reset_fpga),
    .database_request(req_a), .rom_rdata(rom_a),
    .o_rom_addr(addr_a), .o_valid(v_a), .o_data(data_a),
    .o_index_database(ip_a), .o_index_classifier(ic_a),
    .o_index_tree(it_a), .o_end_single_classifier(es_a),
    .o_end_tree(et_a), .o_end_all_classifier(ea_a),
    .o_end_database(ed_a)
  );

  haar_database_streamer #(
    .NUM_TREES(1), .NUM_CLASSIFIER_PER_TREE(1),
    .NUM_PARAM_PER_CLASSIFIER(1), .BASE_ADDR(0)
  ) dut_b (
    .clk_fpga(clk_fpga), .reset_fpga(reset_fpga),
    .database_request(req_b), .rom_rdata(rom_b),
    .o_rom_addr(addr_b), .o_valid(v_b), .o_data(data_b),
    .o_index_database(ip_b), .o_index_classifier(ic_b),
    .o_index_tree(it_b), .o_end_single_classifier(es_b),
    .o_end_tree(et_b), .o_end_all_classifier(ea_b),
    .o_end_database(ed_b)
  );

  haar_database_streamer #(
    .NUM_TREES(2), .NUM_CLASSIFIER_PER_TREE(3),
    .NUM_PARAM_PER_CLASSIFIER(18), .BASE_ADDR(200)
  ) dut_c (
    .clk_fpga(clk_fpga), .reset_fpga(reset_fpga),
    .database_request(req_c), .rom_rdata(rom_c),
    .o_rom_addr(addr_c), .o_valid(v_c), .o_data(data_c),
    .o_index_database(ip_c), .o_index_classifier(ic_c),
    .o_index_tree(it_c), .o_end_single_classifier(es_c),
    .o_end_tree(et_c), .o_end_all_classifier(ea_c),
    .o_end_database(ed_c)
  );

  task automatic step();
    @(posedge clk_fpga);
    #2;
  endtask

  task automatic test_reset();
    reset_fpga = 1'b0;
    repeat (3) step();
    checks++;
    if ({v_a, es_a, et_a, ea_a, ed_a} !== 5'b0 || addr_a !== 12'd0)
      $display("FAIL reset_init flags=%b addr=%0d exp flags=0 addr=0",
               {v_a, es_a, et_a, ea_a, ed_a}, addr_a);
    else passes++;
    reset_fpga = 1'b1;
    req_a = 1'b1;
    repeat (6) step();
    checks++;
    if (v_a !== 1'b1 || data_a !== 12'd5)
      $display("FAIL reset_prestream v=%b data=%0d exp v=1 data=5", v_a, data_a);
    else passes++;
    reset_fpga = 1'b0;
    repeat (3) step();
    checks++;
    if ({v_a, es_a, et_a, ea_a, ed_a} !== 5'b0 || addr_a !== 12'd0)
      $display("FAIL reset_mid flags=%b addr=%0d exp flags=0 addr=0",
               {v_a, es_a, et_a, ea_a, ed_a}, addr_a);
    else passes++;
    checks++;
    if ({ip_a, ic_a, it_a} !== 36'd0)
      $display("FAIL reset_idx p=%0d c=%0d t=%0d exp 0,0,0", ip_a, ic_a, it_a);
    else passes++;
    req_a = 1'b0;
    reset_fpga = 1'b1;
    step();
    checks++;
    if (v_a !== 1'b0 || addr_a !== 12'd0)
      $display("FAIL reset_release v=%b addr=%0d exp v=0 addr=0", v_a, addr_a);
    else passes++;
  endtask

  task automatic test_full_stage();
    int errs;
    logic es, et, ea;
    req_a = 1'b1;
    step();
    errs = 0;
    for (int i = 0; i < 108; i++) begin
      es = (i % 18) == 17;
      et = es && ((i / 18) % 3) == 2;
      ea = et && (i / 54) == 1;
      if (v_a !== 1'b1 || data_a !== 12'(i) ||
          ip_a !== 12'(i % 18) || ic_a !== 12'((i / 18) % 3) ||
          it_a !== 12'(i / 54) || es_a !== es || et_a !== et ||
          ea_a !== ea || ed_a !== 1'b0) begin
        if (errs < 5)
          $display("FAIL full_word%0d v=%b d=%0d idx=%0d/%0d/%0d fl=%b%b%b exp d=%0d fl=%b%b%b",
                   i, v_a, data_a, it_a, ic_a, ip_a, es_a, et_a, ea_a,
                   i, es, et, ea);
        errs++;
      end
      step();
    end
    checks++;
    if (errs != 0)
      $display("FAIL full_stream bad_words=%0d exp 0", errs);
    else passes++;
    checks++;
    if (ed_a !== 1'b1 || v_a !== 1'b0)
      $display("FAIL full_done end_db=%b v=%b exp end_db=1 v=0", ed_a, v_a);
    else passes++;
  endtask

  task automatic test_done_hold();
    int errs = 0;
    for (int i = 0; i < 10; i++) begin
      if (ed_a !== 1'b1 || v_a !== 1'b0 || data_a !== 12'd0) errs++;
      step();
    end
    checks++;
    if (errs != 0)
      $display("FAIL done_hold bad_cycles=%0d exp 0", errs);
    else passes++;
    req_a = 1'b0;
    step();
    checks++;
    if (ed_a !== 1'b0 || v_a !== 1'b0)
      $display("FAIL done_release end_db=%b v=%b exp 0 0", ed_a, v_a);
    else passes++;
    req_a = 1'b1;
    step();
    checks++;
    if (v_a !== 1'b1 || data_a !== 12'd0 || ed_a !== 1'b0 ||
        {ip_a, ic_a, it_a} !== 36'd0)
      $display("FAIL done_restart v=%b d=%0d end_db=%b exp v=1 d=0 end_db=0",
               v_a, data_a, ed_a);
    else passes++;
    req_a = 1'b0;
    step();
  endtask

  task automatic test_abort();
    int errs = 0;
    req_a = 1'b1;
    step();
    for (int i = 0; i <= 40; i++) begin
      if (v_a !== 1'b1 || data_a !== 12'(i) || ea_a !== 1'b0) errs++;
      if (i < 40) step();
    end
    checks++;
    if (errs != 0)
      $display("FAIL abort_prefix bad_words=%0d exp 0", errs);
    else passes++;
    req_a = 1'b0;
    #1;
    checks++;
    if (v_a !== 1'b0 || data_a !== 12'd0 || es_a !== 1'b0)
      $display("FAIL abort_kill v=%b d=%0d exp v=0 d=0", v_a, data_a);
    else passes++;
    step();
    checks++;
    if (v_a !== 1'b0 || addr_a !== 12'd0 || ed_a !== 1'b0)
      $display("FAIL abort_idle v=%b addr=%0d end_db=%b exp 0 0 0", v_a, addr_a, ed_a);
    else passes++;
    req_a = 1'b1;
    step();
    checks++;
    if (v_a !== 1'b1 || data_a !== 12'd0 || {ip_a, ic_a, it_a} !== 36'd0)
      $display("FAIL abort_restart v=%b d=%0d idx=%0d/%0d/%0d exp v=1 d=0 idx=0/0/0",
               v_a, data_a, it_a, ic_a, ip_a);
    else passes++;
    errs = 0;
    for (int i = 0; i < 108; i++) begin
      if (v_a !== 1'b1 || data_a !== 12'(i) || ea_a !== (i == 107)) errs++;
      step();
    end
    checks++;
    if (errs != 0 || ed_a !== 1'b1)
      $display("FAIL abort_full bad_words=%0d end_db=%b exp 0 1", errs, ed_a);
    else passes++;
    req_a = 1'b0;
    step();
  endtask

  task automatic test_degenerate();
    req_b = 1'b1;
    step();
    checks++;
    if (v_b !== 1'b1 || data_b !== 12'd0 || {es_b, et_b, ea_b} !== 3'b111)
      $display("FAIL degen_word v=%b d=%0d fl=%b%b%b exp v=1 d=0 fl=111",
               v_b, data_b, es_b, et_b, ea_b);
    else passes++;
    step();
    checks++;
    if (v_b !== 1'b0 || ed_b !== 1'b1 || addr_b !== 12'd0)
      $display("FAIL degen_done v=%b end_db=%b addr=%0d exp 0 1 0", v_b, ed_b, addr_b);
    else passes++;
    req_b = 1'b0;
    step();
    checks++;
    if (ed_b !== 1'b0)
      $display("FAIL degen_idle end_db=%b exp 0", ed_b);
    else passes++;
  endtask

  task automatic test_base_addr();
    int errs = 0;
    checks++;
    if (addr_c !== 12'd200)
      $display("FAIL base_idle addr=%0d exp 200", addr_c);
    else passes++;
    req_c = 1'b1;
    step();
    for (int i = 0; i < 108; i++) begin
      if (v_c !== 1'b1 || data_c !== 12'(200 + i) ||
          addr_c !== 12'(201 + i) || ea_c !== (i == 107)) begin
        if (errs < 5)
          $display("FAIL base_word%0d d=%0d addr=%0d ea=%b exp d=%0d addr=%0d",
                   i, data_c, addr_c, ea_c, 200 + i, 201 + i);
        errs++;
      end
      step();
    end
    checks++;
    if (errs != 0)
      $display("FAIL base_stream bad_words=%0d exp 0", errs);
    else passes++;
    checks++;
    if (addr_c !== 12'd200 || ed_c !== 1'b1 || v_c !== 1'b0)
      $display("FAIL base_done addr=%0d end_db=%b v=%b exp 200 1 0", addr_c, ed_c, v_c);
    else passes++;
    req_c = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_full_stage();
    test_done_hold();
    test_abort();
    test_degenerate();
    test_base_addr();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
